dec_scan_ctrl: RTL and testbench
================================

Name: dec_scan_ctrl

Overview:
Parametrised registered binary-to-one-hot decoder, the successor to the fixed 3-to-8 combinational decoder. It adds a registered output, an enable, and a load strobe, plus an auto-scan mode. In scan mode an internal divider and index counter step the active line through 0..scan_last, for time-multiplexed digit and row select. It sits between control logic and display/row drivers.

Parameters:
SEL_W, 3, index width; output width OUT_W = 2**SEL_W (localparam, not overridable)
MSB_FIRST, 1, 1: index i drives out[OUT_W-1-i] (index 0 on the MSB, as in the existing 3-to-8 decoder); 0: index i drives out[i]
SCAN_DIV, 4, clock cycles per scan step; legal range 1..65535; divider width is $clog2(SCAN_DIV+1)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  block enable; 0 forces IDLE
mode  input  1  0 = direct, 1 = scan
sel  input  SEL_W  direct-mode index
sel_vld  input  1  load strobe for sel (direct mode)
scan_last  input  SEL_W  final index of the scan sequence (inclusive)
out  output  OUT_W  registered one-hot select (active-high by default)
idx  output  SEL_W  index currently driven
wrap  output  1  one-cycle pulse when scan returns to index 0

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, out=all inactive, idx=0, wrap=0, divider=0. Overrides every other input. Reset mid-scan is effective on the same edge.
- All outputs are registered. out changes 1 cycle after the inputs that cause it.
- In DIRECT and SCAN, out is exactly one-hot and equals decode(idx) under MSB_FIRST. In IDLE, out is all inactive.
- FSM priority, highest first: rst_n, en=0, mode, sel_vld.
- IDLE:
  - en=1, mode=1 -> SCAN; idx=0; divider=0.
  - en=1, mode=0, sel_vld=1 -> DIRECT; idx=sel.
  - Otherwise stay in IDLE.
- DIRECT:
  - sel_vld=1 -> idx=sel next cycle; otherwise idx holds.
  - mode=1 -> SCAN; idx=0; divider=0. sel_vld is ignored in that cycle.
  - en=0 -> IDLE.
- SCAN:
  - Divider counts 0..SCAN_DIV-1.
  - At terminal count: divider=0, and idx advances.
    - If idx >= scan_last: idx=0, wrap=1 for that one cycle.
    - Otherwise: idx=idx+1.
  - Every index is therefore held for exactly SCAN_DIV cycles.
  - SCAN_DIV=1 steps idx every cycle.
  - mode=0 -> DIRECT with idx=sel if sel_vld=1, else -> IDLE.
  - en=0 -> IDLE.
- scan_last boundary cases:
  - scan_last=0: idx stays 0, and wrap pulses every SCAN_DIV cycles.
  - scan_last lowered below the current idx: at the next step, idx goes to 0 with wrap=1. No out-of-range stepping.
  - scan_last is sampled at each step, not latched.
- sel and scan_last are unsigned. All 2**SEL_W codes are legal. No out-of-range case exists.
- wrap is 0 in every state except the wrap cycle in SCAN.
- Re-entering SCAN always restarts at idx=0 with a full divider period.

Optional Feature:
Macro: DEC_ACTIVE_LOW_EN.
- Defined: out is active-low. The selected bit is 0 and all others are 1. The IDLE and reset value is all ones (8'hFF at SEL_W=3).
- Undefined: out is active-high, as described above, and the reset value is all zeros.
- idx and wrap are unaffected either way.

Test Plan:
All scenarios use defaults SEL_W=3, MSB_FIRST=1, SCAN_DIV=4.
1. Reset: hold rst_n=0 for 2 edges with en=1, mode=1 -> out=8'h00, idx=0, wrap=0. Release -> SCAN begins, out=8'h80 one cycle later.
2. Direct load: en=1, mode=0, pulse sel_vld with sel=0, then 7, then 5 -> out=8'h80, 8'h01, 8'h04, each 1 cycle after its strobe. A sweep of all 8 codes gives exactly one bit set at out[7-sel]. With MSB_FIRST=0, sel=5 gives 8'h20.
3. Scan: en=1, mode=1, scan_last=3 -> out=8'h80, 40, 20, 10, each held 4 cycles, then 8'h80 again with wrap=1 for a single cycle. Period is 16 cycles.
4. Boundary: scan_last=7 and idx=5, then change scan_last to 1 -> at the next step idx=0, wrap=1. The sequence then alternates 8'h80 and 8'h40.
5. Interrupt: drop en mid-scan (idx=2) -> next cycle out=8'h00, wrap=0. Re-assert en with mode=1 -> restarts at 8'h80 with a full 4-cycle hold. Assert rst_n=0 mid-scan -> IDLE on that edge.
6. Feature on: with DEC_ACTIVE_LOW_EN defined -> reset out=8'hFF. Direct load of sel=2 -> 8'hDF. en=0 -> 8'hFF.

Source files
------------

// File: rtl/dec_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dec_scan_ctrl
// Purpose : Registered binary-to-one-hot decoder with enable, load strobe and
//           auto-scan mode. Define DEC_ACTIVE_LOW_EN for active-low outputs.
// Revision: 1.0 - initial release
// ============================================================================
module dec_scan_ctrl #(
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned SCAN_DIV  = 4,
    localparam int unsigned OUT_W    = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_vld,
    input  logic [SEL_W-1:0] scan_last,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV + 1);
    localparam logic [DIV_W-1:0] c_div_tc = DIV_W'(SCAN_DIV - 1);
    localparam logic [OUT_W-1:0] c_one    = OUT_W'(1);

    // Value driven on out while idle; the active pattern is this XOR one-hot.
`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [OUT_W-1:0] c_out_idle = {OUT_W{1'b1}};
`else
    localparam logic [OUT_W-1:0] c_out_idle = {OUT_W{1'b0}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] w_idx_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic [OUT_W-1:0] r_out;
    logic [OUT_W-1:0] w_out_nxt;
    logic [OUT_W-1:0] w_shift;
    logic [OUT_W-1:0] w_onehot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_div   <= '0;
            r_wrap  <= 1'b0;
            r_out   <= c_out_idle;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_div   <= w_div_nxt;
            r_wrap  <= w_wrap_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Priority: en, then mode, then sel_vld. Divider only runs inside SCAN.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_div_nxt   = '0;
        w_wrap_nxt  = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DIRECT: begin
                    if (mode) begin
                        w_state_nxt = ST_SCAN;
                        w_idx_nxt   = '0;
                    end else if (sel_vld) begin
                        w_state_nxt = ST_DIRECT;
                        w_idx_nxt   = sel;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        if (sel_vld) begin
                            w_state_nxt = ST_DIRECT;
                            w_idx_nxt   = sel;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (r_div == c_div_tc) begin
                        // scan_last is live: lowering it below idx wraps at once
                        if (r_idx >= scan_last) begin
                            w_idx_nxt  = '0;
                            w_wrap_nxt = 1'b1;
                        end else begin
                            w_idx_nxt  = r_idx + SEL_W'(1);
                        end
                    end else begin
                        w_div_nxt = r_div + DIV_W'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_shift = c_one << w_idx_nxt;

    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_decode
        if (MSB_FIRST != 0) begin : g_msb
            assign w_onehot[OUT_W-1-gi] = w_shift[gi];
        end else begin : g_lsb
            assign w_onehot[gi] = w_shift[gi];
        end
    end

    assign w_out_nxt = (w_state_nxt == ST_IDLE) ? c_out_idle : (c_out_idle ^ w_onehot);

    assign out  = r_out;
    assign idx  = r_idx;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_dec_scan_ctrl.sv
`default_nettype none
// Testbench for dec_scan_ctrl: table-driven direct-mode vectors plus
// hand-written scan, boundary, interrupt and reset sequences.
module tb_dec_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, en, mode, sel_vld;
    logic [2:0] sel, scan_last;
    logic [7:0] out, out_lsb;
    logic [2:0] idx, idx_lsb;
    logic       wrap, wrap_lsb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dec_scan_ctrl #(.SEL_W(3), .MSB_FIRST(1), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .sel_vld(sel_vld), .scan_last(scan_last),
        .out(out), .idx(idx), .wrap(wrap)
    );

    dec_scan_ctrl #(.SEL_W(3), .MSB_FIRST(0), .SCAN_DIV(4)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .sel_vld(sel_vld), .scan_last(scan_last),
        .out(out_lsb), .idx(idx_lsb), .wrap(wrap_lsb)
    );

    typedef struct {
        logic       rst_n, en, mode, sel_vld;
        logic [2:0] sel, last;
        logic [7:0] exp_out, exp_lsb;
        logic [2:0] exp_idx;
        logic       chk_idx;
        logic       exp_wrap;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [7:0] pol(input logic [7:0] x);
`ifdef DEC_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_scan(input string name, input int t, input logic [2:0] e_idx, input logic e_wrap);
        chk($sformatf("%s t=%0d out", name, t), out, pol(8'h80 >> e_idx));
        chk($sformatf("%s t=%0d idx", name, t), idx, e_idx);
        chk($sformatf("%s t=%0d wrap", name, t), wrap, e_wrap);
    endtask

    initial begin
        //          rst en md vld sel  last  out    lsb    idx  ci  wr
        tbl[0]  = '{0, 1, 1, 0, 3'd0, 3'd3, 8'h00, 8'h00, 3'd0, 1, 0};
        tbl[1]  = '{0, 1, 1, 0, 3'd0, 3'd3, 8'h00, 8'h00, 3'd0, 1, 0};
        tbl[2]  = '{1, 1, 1, 0, 3'd0, 3'd3, 8'h80, 8'h01, 3'd0, 1, 0};
        tbl[3]  = '{1, 0, 1, 0, 3'd0, 3'd3, 8'h00, 8'h00, 3'd0, 0, 0};
        tbl[4]  = '{1, 1, 0, 1, 3'd0, 3'd3, 8'h80, 8'h01, 3'd0, 1, 0};
        tbl[5]  = '{1, 1, 0, 0, 3'd3, 3'd3, 8'h80, 8'h01, 3'd0, 1, 0};
        tbl[6]  = '{1, 1, 0, 1, 3'd7, 3'd3, 8'h01, 8'h80, 3'd7, 1, 0};
        tbl[7]  = '{1, 1, 0, 1, 3'd5, 3'd3, 8'h04, 8'h20, 3'd5, 1, 0};
        tbl[8]  = '{1, 1, 0, 0, 3'd1, 3'd3, 8'h04, 8'h20, 3'd5, 1, 0};
        tbl[9]  = '{1, 0, 0, 1, 3'd2, 3'd3, 8'h00, 8'h00, 3'd0, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 3'd2, 3'd3, 8'h00, 8'h00, 3'd0, 0, 0};
        tbl[11] = '{1, 1, 0, 1, 3'd2, 3'd3, 8'h20, 8'h04, 3'd2, 1, 0};
        tbl[12] = '{1, 1, 1, 1, 3'd6, 3'd3, 8'h80, 8'h01, 3'd0, 1, 0};

        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_vld = 1'b0; sel = '0; scan_last = '0;

        for (int i = 0; i < 13; i++) begin
            rst_n = tbl[i].rst_n; en = tbl[i].en; mode = tbl[i].mode;
            sel_vld = tbl[i].sel_vld; sel = tbl[i].sel; scan_last = tbl[i].last;
            tick();
            chk($sformatf("row%0d out", i), out, pol(tbl[i].exp_out));
            chk($sformatf("row%0d out_lsb", i), out_lsb, pol(tbl[i].exp_lsb));
            chk($sformatf("row%0d wrap", i), wrap, tbl[i].exp_wrap);
            if (tbl[i].chk_idx)
                chk($sformatf("row%0d idx", i), idx, tbl[i].exp_idx);
        end

        // Scan 0..3, each held 4 cycles, wrap on return to 0 at t=16
        sel_vld = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            tick();
            chk_scan("scan", t, 3'((t / 4) % 4), t == 16);
        end

        // Leave scan to DIRECT with a load, re-enter, leave to IDLE
        mode = 1'b0; sel_vld = 1'b1; sel = 3'd6;
        tick();
        chk("scan2direct out", out, pol(8'h02));
        chk("scan2direct idx", idx, 3'd6);
        mode = 1'b1; sel_vld = 1'b0;
        tick();
        chk_scan("reenter", 0, 3'd0, 1'b0);
        mode = 1'b0;
        tick();
        chk("scan2idle out", out, pol(8'h00));
        chk("scan2idle wrap", wrap, 1'b0);

        // Direct sweep of all codes
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s); sel_vld = 1'b1;
            tick();
            chk($sformatf("sweep%0d out", s), out, pol(8'h80 >> s));
            chk($sformatf("sweep%0d out_lsb", s), out_lsb, pol(8'h01 << s));
        end

        // scan_last lowered below idx=5 forces wrap at the next step
        sel_vld = 1'b0; mode = 1'b1; scan_last = 3'd7;
        tick();
        chk_scan("bnd", 0, 3'd0, 1'b0);
        for (int t = 1; t <= 40; t++) begin
            if (t == 22) scan_last = 3'd1;
            tick();
            if (t < 24) chk_scan("bnd", t, 3'(t / 4), 1'b0);
            else        chk_scan("bnd", t, 3'(((t - 24) / 4) % 2), ((t - 24) % 8) == 0);
        end

        // scan_last = 0: idx pinned at 0, wrap every 4 cycles
        en = 1'b0;
        tick();
        en = 1'b1; scan_last = 3'd0;
        tick();
        chk_scan("last0", 0, 3'd0, 1'b0);
        for (int t = 1; t <= 9; t++) begin
            tick();
            chk_scan("last0", t, 3'd0, (t % 4) == 0);
        end

        // Drop en mid-scan, restart, then reset mid-scan
        en = 1'b0;
        tick();
        en = 1'b1; scan_last = 3'd3;
        tick();
        for (int t = 1; t <= 8; t++) tick();
        chk_scan("intr pre", 8, 3'd2, 1'b0);
        en = 1'b0;
        tick();
        chk("intr off out", out, pol(8'h00));
        chk("intr off wrap", wrap, 1'b0);
        en = 1'b1;
        tick();
        chk_scan("restart", 0, 3'd0, 1'b0);
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk_scan("restart", t, 3'(t / 4), 1'b0);
        end
        rst_n = 1'b0;
        tick();
        chk("midrst out", out, pol(8'h00));
        chk("midrst idx", idx, 3'd0);
        chk("midrst wrap", wrap, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_scan("postrst", 0, 3'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
